// File: rtl/sfif_pkg.sv
// Shared SFIF definitions: TLP tag-field placement and default pool widths.
package sfif_pkg;

  localparam int SFIF_TAG_W_DEF  = 5;
  localparam int SFIF_CNT_W_DEF  = 4;
  localparam int SFIF_TICK_W_DEF = 10;
  localparam int SFIF_AGE_W_DEF  = 3;

  // Tag field inside request header DW1 / completion header DW2
  localparam int TLP_TAG_LSB = 8;
  localparam int TLP_TAG_MSB = 15;

  function automatic logic [TLP_TAG_MSB-TLP_TAG_LSB:0] tlp_get_tag(input logic [31:0] dw);
    return dw[TLP_TAG_MSB:TLP_TAG_LSB];
  endfunction

endpackage

// File: rtl/sfif_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag; idx is zero when nothing is set.
module sfif_prio_enc #(
  parameter int W     = 32,
  parameter int IDX_W = 5
) (
  input  logic [W-1:0]     req,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sfif_tag_pool.sv
// Non-posted tag pool: allocates lowest free tag, tracks outstanding completions,
// ages busy tags on a prescaled tick and reports timeouts one per cycle.
module sfif_tag_pool
  import sfif_pkg::*;
#(
  parameter int TAG_W  = SFIF_TAG_W_DEF,
  parameter int CNT_W  = SFIF_CNT_W_DEF,
  parameter int TICK_W = SFIF_TICK_W_DEF,
  parameter int AGE_W  = SFIF_AGE_W_DEF
) (
  input  logic             clk_125,
  input  logic             rstn,
  input  logic             flush,
  input  logic             alloc_req,
  input  logic [CNT_W-1:0] alloc_cplds,
  output logic             alloc_rdy,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cpl_vld,
  input  logic [TAG_W-1:0] cpl_tag,
  output logic             err_unexp,
  output logic             tmo_vld,
  output logic [TAG_W-1:0] tmo_tag,
  output logic [TAG_W:0]   free_cnt
);

  localparam int NT = 1 << TAG_W;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NT];
  logic [CNT_W-1:0]  cnt_d [NT];
  logic [AGE_W-1:0]  age_q [NT];
  logic [AGE_W-1:0]  age_d [NT];
  logic [NT-1:0]     pend_q, pend_d;
  logic [TICK_W-1:0] presc_q, presc_d;

  logic             alloc_rdy_q, alloc_rdy_d;
  logic [TAG_W-1:0] alloc_tag_q, alloc_tag_d;
  logic [TAG_W:0]   free_cnt_q, free_cnt_d;
  logic             err_unexp_q, err_unexp_d;
  logic             tmo_vld_q, tmo_vld_d;
  logic [TAG_W-1:0] tmo_tag_q, tmo_tag_d;

  logic [NT-1:0]    free_vec;
  logic             free_vld;
  logic [TAG_W-1:0] free_idx;
  logic             tmo_sel_vld;
  logic [TAG_W-1:0] tmo_sel_idx;
  logic             grant;
  logic             tick;

  assign grant = alloc_req & alloc_rdy_q;
  assign tick  = &presc_q;

  sfif_prio_enc #(.W(NT), .IDX_W(TAG_W)) u_tmo_sel (
    .req (pend_q),
    .vld (tmo_sel_vld),
    .idx (tmo_sel_idx)
  );

  sfif_prio_enc #(.W(NT), .IDX_W(TAG_W)) u_free_sel (
    .req (free_vec),
    .vld (free_vld),
    .idx (free_idx)
  );

  // Pending and idle tags both hold cnt==0, so a zero count is the idle test
  // for completions; the tag being granted is also free, hence idle.
  always_comb begin
    cnt_d       = cnt_q;
    age_d       = age_q;
    pend_d      = pend_q;
    presc_d     = presc_q + 1'b1;
    err_unexp_d = 1'b0;
    tmo_vld_d   = tmo_sel_vld;
    tmo_tag_d   = tmo_sel_idx;

    if (tmo_sel_vld) begin
      pend_d[tmo_sel_idx] = 1'b0;
    end

    if (tick) begin
      for (int t = 0; t < NT; t++) begin
        if (cnt_q[t] != '0) begin
          age_d[t] = age_q[t] + 1'b1;
          if (age_q[t] == AGE_MAX - 1'b1) begin
            pend_d[t] = 1'b1;
            cnt_d[t]  = '0;
          end
        end
      end
    end

    // A completion in the saturating tick cycle still counts: it wins over the timeout.
    if (cpl_vld) begin
      if (cnt_q[cpl_tag] != '0) begin
        cnt_d[cpl_tag]  = cnt_q[cpl_tag] - 1'b1;
        age_d[cpl_tag]  = '0;
        pend_d[cpl_tag] = 1'b0;
      end else begin
        err_unexp_d = 1'b1;
      end
    end

    if (grant) begin
      cnt_d[alloc_tag_q] = (alloc_cplds == '0) ? CNT_W'(1) : alloc_cplds;
      age_d[alloc_tag_q] = '0;
    end

    if (flush) begin
      for (int t = 0; t < NT; t++) begin
        cnt_d[t] = '0;
        age_d[t] = '0;
      end
      pend_d      = '0;
      presc_d     = '0;
      err_unexp_d = 1'b0;
      tmo_vld_d   = 1'b0;
      tmo_tag_d   = '0;
    end
  end

  always_comb begin
    free_cnt_d = '0;
    for (int t = 0; t < NT; t++) begin
      free_vec[t] = (cnt_d[t] == '0) && !pend_d[t];
      free_cnt_d  = free_cnt_d + (TAG_W+1)'(free_vec[t]);
    end
    alloc_rdy_d = free_vld;
    alloc_tag_d = free_idx;
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < NT; t++) begin
        cnt_q[t] <= '0;
        age_q[t] <= '0;
      end
      pend_q      <= '0;
      presc_q     <= '0;
      alloc_rdy_q <= 1'b0;
      alloc_tag_q <= '0;
      free_cnt_q  <= '0;
      err_unexp_q <= 1'b0;
      tmo_vld_q   <= 1'b0;
      tmo_tag_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      age_q       <= age_d;
      pend_q      <= pend_d;
      presc_q     <= presc_d;
      alloc_rdy_q <= alloc_rdy_d;
      alloc_tag_q <= alloc_tag_d;
      free_cnt_q  <= free_cnt_d;
      err_unexp_q <= err_unexp_d;
      tmo_vld_q   <= tmo_vld_d;
      tmo_tag_q   <= tmo_tag_d;
    end
  end

  assign alloc_rdy = alloc_rdy_q;
  assign alloc_tag = alloc_tag_q;
  assign free_cnt  = free_cnt_q;
  assign err_unexp = err_unexp_q;
  assign tmo_vld   = tmo_vld_q;
  assign tmo_tag   = tmo_tag_q;

endmodule

// File: tb/tb_sfif_tag_pool.sv
// Bench for sfif_tag_pool: a fast-tick (TICK_W=2) and a default-tick instance share
// stimulus and are both tracked by a tag-table reference model.
module tb_sfif_tag_pool;

  localparam int TAG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int AGE_W   = 3;
  localparam int NT      = 32;
  localparam int TMO_TCK = 7;

  logic             clk_125 = 1'b0;
  logic             rstn = 1'b0;
  logic             flush = 1'b0;
  logic             alloc_req = 1'b0;
  logic [CNT_W-1:0] alloc_cplds = '0;
  logic             cpl_vld = 1'b0;
  logic [TAG_W-1:0] cpl_tag = '0;

  logic             rdy_o     [2];
  logic [TAG_W-1:0] tag_o     [2];
  logic             err_o     [2];
  logic             tmo_o     [2];
  logic [TAG_W-1:0] tmo_tag_o [2];
  logic [TAG_W:0]   free_o    [2];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per instance, table of outstanding completions, ticks of age,
  // timed-out-but-unreported flags, prescaler position and expected outputs.
  int m_cnt   [2][NT];
  int m_age   [2][NT];
  bit m_pend  [2][NT];
  int m_presc [2];
  bit e_rdy [2];
  int e_tag [2];
  int e_free [2];
  bit e_err [2];
  bit e_tmo [2];
  int e_tmo_tag [2];

  always #4 clk_125 = ~clk_125;

  sfif_tag_pool #(.TAG_W(TAG_W), .CNT_W(CNT_W), .TICK_W(2), .AGE_W(AGE_W)) u_fast (
    .clk_125(clk_125), .rstn(rstn), .flush(flush), .alloc_req(alloc_req),
    .alloc_cplds(alloc_cplds), .alloc_rdy(rdy_o[0]), .alloc_tag(tag_o[0]),
    .cpl_vld(cpl_vld), .cpl_tag(cpl_tag), .err_unexp(err_o[0]),
    .tmo_vld(tmo_o[0]), .tmo_tag(tmo_tag_o[0]), .free_cnt(free_o[0])
  );

  sfif_tag_pool #(.TAG_W(TAG_W), .CNT_W(CNT_W), .TICK_W(10), .AGE_W(AGE_W)) u_slow (
    .clk_125(clk_125), .rstn(rstn), .flush(flush), .alloc_req(alloc_req),
    .alloc_cplds(alloc_cplds), .alloc_rdy(rdy_o[1]), .alloc_tag(tag_o[1]),
    .cpl_vld(cpl_vld), .cpl_tag(cpl_tag), .err_unexp(err_o[1]),
    .tmo_vld(tmo_o[1]), .tmo_tag(tmo_tag_o[1]), .free_cnt(free_o[1])
  );

  function automatic int period(input int i);
    return (i == 0) ? 4 : 1024;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int t = 0; t < NT; t++) begin
        m_cnt[i][t] = 0; m_age[i][t] = 0; m_pend[i][t] = 0;
      end
      m_presc[i] = 0;
      e_rdy[i] = 0; e_tag[i] = 0; e_free[i] = 0;
      e_err[i] = 0; e_tmo[i] = 0; e_tmo_tag[i] = 0;
    end
  endtask

  task automatic model_step();
    int old_cnt [NT];
    int g_tag;
    bit grant;
    for (int i = 0; i < 2; i++) begin
      g_tag = e_tag[i];
      grant = alloc_req && e_rdy[i];
      for (int t = 0; t < NT; t++) old_cnt[t] = m_cnt[i][t];
      e_tmo[i] = 0; e_tmo_tag[i] = 0; e_err[i] = 0;
      for (int t = 0; t < NT; t++) begin
        if (m_pend[i][t]) begin
          e_tmo[i] = 1; e_tmo_tag[i] = t; m_pend[i][t] = 0;
          break;
        end
      end
      if (m_presc[i] == period(i) - 1) begin
        for (int t = 0; t < NT; t++) begin
          if (old_cnt[t] > 0) begin
            m_age[i][t]++;
            if (m_age[i][t] >= TMO_TCK) begin m_pend[i][t] = 1; m_cnt[i][t] = 0; end
          end
        end
      end
      m_presc[i] = (m_presc[i] + 1) % period(i);
      if (cpl_vld) begin
        if (old_cnt[cpl_tag] > 0) begin
          m_cnt[i][cpl_tag] = old_cnt[cpl_tag] - 1;
          m_age[i][cpl_tag] = 0;
          m_pend[i][cpl_tag] = 0;
        end else begin
          e_err[i] = 1;
        end
      end
      if (grant) begin
        m_cnt[i][g_tag] = (alloc_cplds == 0) ? 1 : int'(alloc_cplds);
        m_age[i][g_tag] = 0;
      end
      if (flush) begin
        for (int t = 0; t < NT; t++) begin
          m_cnt[i][t] = 0; m_age[i][t] = 0; m_pend[i][t] = 0;
        end
        m_presc[i] = 0;
        e_err[i] = 0; e_tmo[i] = 0; e_tmo_tag[i] = 0;
      end
      e_free[i] = 0; e_rdy[i] = 0; e_tag[i] = 0;
      for (int t = NT - 1; t >= 0; t--) begin
        if (m_cnt[i][t] == 0 && !m_pend[i][t]) begin
          e_free[i]++; e_rdy[i] = 1; e_tag[i] = t;
        end
      end
    end
  endtask

  // Advance one clock and hold both instances against the model.
  task automatic cycle();
    model_step();
    @(posedge clk_125); #1;
    for (int i = 0; i < 2; i++) begin
      vectors += 6;
      if (rdy_o[i] !== e_rdy[i]) begin
        miscompares++; $display("FAIL model_rdy[%0d] t=%0t got %b exp %b", i, $time, rdy_o[i], e_rdy[i]);
      end
      if (tag_o[i] !== TAG_W'(e_tag[i])) begin
        miscompares++; $display("FAIL model_tag[%0d] t=%0t got %0d exp %0d", i, $time, tag_o[i], e_tag[i]);
      end
      if (free_o[i] !== (TAG_W+1)'(e_free[i])) begin
        miscompares++; $display("FAIL model_free[%0d] t=%0t got %0d exp %0d", i, $time, free_o[i], e_free[i]);
      end
      if (err_o[i] !== e_err[i]) begin
        miscompares++; $display("FAIL model_err[%0d] t=%0t got %b exp %b", i, $time, err_o[i], e_err[i]);
      end
      if (tmo_o[i] !== e_tmo[i]) begin
        miscompares++; $display("FAIL model_tmo[%0d] t=%0t got %b exp %b", i, $time, tmo_o[i], e_tmo[i]);
      end
      if (tmo_tag_o[i] !== TAG_W'(e_tmo_tag[i])) begin
        miscompares++; $display("FAIL model_tmo_tag[%0d] t=%0t got %0d exp %0d", i, $time, tmo_tag_o[i], e_tmo_tag[i]);
      end
    end
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_req = 0; alloc_cplds = '0; cpl_vld = 0; cpl_tag = '0;
  endtask

  task automatic do_flush();
    idle_inputs(); flush = 1; cycle(); flush = 0;
  endtask

  task automatic test_reset();
    rstn = 0; idle_inputs(); model_reset();
    #20;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rdy_o[i] !== 1'b0 || tag_o[i] !== '0 || free_o[i] !== '0 ||
          err_o[i] !== 1'b0 || tmo_o[i] !== 1'b0 || tmo_tag_o[i] !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d] got rdy=%b tag=%0d free=%0d err=%b tmo=%b tmo_tag=%0d exp all 0",
                 i, rdy_o[i], tag_o[i], free_o[i], err_o[i], tmo_o[i], tmo_tag_o[i]);
      end
    end
    @(posedge clk_125); #1; rstn = 1;
    cycle();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rdy_o[i] !== 1'b1 || free_o[i] !== 6'd32) begin
        miscompares++;
        $display("FAIL first_clock[%0d] got rdy=%b free=%0d exp rdy=1 free=32", i, rdy_o[i], free_o[i]);
      end
    end
  endtask

  task automatic test_alloc_burst();
    alloc_req = 1; alloc_cplds = 4'd2;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (tag_o[1] !== TAG_W'(k)) begin
        miscompares++; $display("FAIL burst_offer got %0d exp %0d", tag_o[1], k);
      end
      cycle();
    end
    idle_inputs();
    vectors++;
    if (free_o[1] !== 6'd29 || tag_o[1] !== 5'd3) begin
      miscompares++; $display("FAIL burst_free got free=%0d tag=%0d exp free=29 tag=3", free_o[1], tag_o[1]);
    end
  endtask

  task automatic test_complete_frees();
    cpl_vld = 1; cpl_tag = 5'd1;
    cycle();
    vectors++;
    if (tag_o[1] !== 5'd3) begin
      miscompares++; $display("FAIL cpl_partial got tag=%0d exp 3", tag_o[1]);
    end
    cycle();
    idle_inputs();
    vectors++;
    if (tag_o[1] !== 5'd1 || free_o[1] !== 6'd30) begin
      miscompares++; $display("FAIL cpl_frees got tag=%0d free=%0d exp tag=1 free=30", tag_o[1], free_o[1]);
    end
  endtask

  task automatic test_unexpected();
    logic [TAG_W:0] free_before;
    free_before = free_o[1];
    cpl_vld = 1; cpl_tag = 5'd7;
    cycle();
    idle_inputs();
    vectors++;
    if (err_o[1] !== 1'b1 || free_o[1] !== free_before) begin
      miscompares++;
      $display("FAIL unexp_pulse got err=%b free=%0d exp err=1 free=%0d", err_o[1], free_o[1], free_before);
    end
    cycle();
    vectors++;
    if (err_o[1] !== 1'b0) begin
      miscompares++; $display("FAIL unexp_one_cycle got err=%b exp 0", err_o[1]);
    end
  endtask

  task automatic test_timeout();
    int waited;
    do_flush();
    for (int k = 0; k < 6; k++) begin
      alloc_req = 1; alloc_cplds = (k == 3 || k == 5) ? 4'd2 : 4'd1;
      cycle();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      cpl_vld = 1; cpl_tag = (k == 3) ? 5'd4 : TAG_W'(k);
      cycle();
    end
    idle_inputs();
    for (int k = 0; k < 4 && m_presc[0] != 0; k++) cycle();
    cpl_vld = 1; cpl_tag = 5'd3; cycle();
    cpl_vld = 1; cpl_tag = 5'd5; cycle();
    idle_inputs();
    waited = 0;
    while (tmo_o[0] !== 1'b1 && waited < 60) begin cycle(); waited++; end
    vectors++;
    if (tmo_o[0] !== 1'b1 || tmo_tag_o[0] !== 5'd3) begin
      miscompares++; $display("FAIL tmo_first got vld=%b tag=%0d exp vld=1 tag=3", tmo_o[0], tmo_tag_o[0]);
    end
    cycle();
    vectors++;
    if (tmo_o[0] !== 1'b1 || tmo_tag_o[0] !== 5'd5 || free_o[0] !== 6'd32) begin
      miscompares++;
      $display("FAIL tmo_second got vld=%b tag=%0d free=%0d exp vld=1 tag=5 free=32", tmo_o[0], tmo_tag_o[0], free_o[0]);
    end
    cycle();
    vectors++;
    if (tmo_o[0] !== 1'b0) begin
      miscompares++; $display("FAIL tmo_done got vld=%b exp 0", tmo_o[0]);
    end
  endtask

  task automatic test_full_pool();
    do_flush();
    alloc_req = 1; alloc_cplds = 4'd1;
    for (int k = 0; k < NT + 3; k++) cycle();
    idle_inputs();
    vectors++;
    if (rdy_o[1] !== 1'b0 || free_o[1] !== '0) begin
      miscompares++; $display("FAIL pool_full got rdy=%b free=%0d exp rdy=0 free=0", rdy_o[1], free_o[1]);
    end
    cpl_vld = 1; cpl_tag = 5'd9;
    cycle();
    idle_inputs();
    vectors++;
    if (rdy_o[1] !== 1'b1 || tag_o[1] !== 5'd9 || free_o[1] !== 6'd1) begin
      miscompares++;
      $display("FAIL pool_refill got rdy=%b tag=%0d free=%0d exp rdy=1 tag=9 free=1", rdy_o[1], tag_o[1], free_o[1]);
    end
  endtask

  task automatic test_flush_override();
    do_flush();
    alloc_req = 1; alloc_cplds = 4'd3;
    for (int k = 0; k < 10; k++) cycle();
    flush = 1; cpl_vld = 1; cpl_tag = 5'd2;
    cycle();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (free_o[i] !== 6'd32 || tag_o[i] !== '0 || rdy_o[i] !== 1'b1 || err_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_clear[%0d] got free=%0d tag=%0d rdy=%b err=%b exp 32/0/1/0",
                 i, free_o[i], tag_o[i], rdy_o[i], err_o[i]);
      end
    end
    for (int k = 0; k < 40; k++) begin
      cycle();
      vectors++;
      if (tmo_o[0] !== 1'b0 || tmo_o[1] !== 1'b0) begin
        miscompares++; $display("FAIL flush_no_tmo got fast=%b slow=%b exp 0", tmo_o[0], tmo_o[1]);
      end
    end
  endtask

  task automatic test_random();
    int busy [$];
    do_flush();
    for (int n = 0; n < 1500; n++) begin
      busy.delete();
      for (int t = 0; t < NT; t++) if (m_cnt[0][t] > 0) busy.push_back(t);
      flush       = ($urandom_range(0, 199) == 0);
      alloc_req   = ($urandom_range(0, 2) != 0);
      alloc_cplds = CNT_W'($urandom_range(0, 15));
      cpl_vld     = ($urandom_range(0, 3) != 0);
      if (busy.size() > 0 && $urandom_range(0, 4) != 0)
        cpl_tag = TAG_W'(busy[$urandom_range(0, busy.size() - 1)]);
      else
        cpl_tag = TAG_W'($urandom_range(0, NT - 1));
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    alloc_req = 1; alloc_cplds = 4'd2;
    for (int k = 0; k < 5; k++) cycle();
    cpl_vld = 1; cpl_tag = 5'd0;
    #2 rstn = 0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rdy_o[i] !== 1'b0 || free_o[i] !== '0 || tag_o[i] !== '0 || err_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL midop_reset[%0d] got rdy=%b free=%0d tag=%0d err=%b exp all 0",
                 i, rdy_o[i], free_o[i], tag_o[i], err_o[i]);
      end
    end
    idle_inputs();
    @(posedge clk_125); #1; rstn = 1;
    for (int k = 0; k < 4; k++) cycle();
    vectors++;
    if (free_o[1] !== 6'd32 || err_o[1] !== 1'b0) begin
      miscompares++; $display("FAIL midop_release got free=%0d err=%b exp 32/0", free_o[1], err_o[1]);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_burst();
    test_complete_frees();
    test_unexpected();
    test_timeout();
    test_full_pool();
    test_flush_override();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
